// File: rtl/fir_pkg.sv
// fir_pkg
// Declarations shared by the coefficient loader and the FIR filter.
//   loader_state_t : coefficient loader FSM states
//   ncoef()        : number of stored coefficients for a filter order.
//                    The filter is symmetric, so it keeps only half the taps.
//   addr_width()   : coefficient address width for a filter order
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } loader_state_t;

    function automatic int ncoef(input int ord);
        return (ord + 1) >> 1;
    endfunction

    function automatic int addr_width(input int ord);
        return $clog2(ncoef(ord));
    endfunction

endpackage

// File: rtl/loader_timer.sv
// loader_timer
// Loadable down-counter with a zero flag. The coefficient loader uses it
// both for the inter-beat timeout in LOAD and for the SETTLE duration.
//   clk        : clock
//   nrst       : asynchronous active-low reset (count cleared)
//   load       : load count from load_value (takes priority over dec)
//   load_value : value to load
//   dec        : decrement count by one
//   zero       : count is zero
module loader_timer #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader
// Streams NCOEF coefficients from a valid/ready source into the FIR
// coefficient memory. After the last coefficient, it mutes the filter for
// 2*D clock cycles so that the stale accumulation is flushed. It then
// pulses done.
//   clk        : clock
//   nrst       : asynchronous active-low reset
//   start      : begin a load (honoured only in IDLE)
//   abort      : cancel a load in progress
//   s_valid    : coefficient beat valid
//   s_data     : coefficient value, in index order
//   s_ready    : loader accepts a beat (high exactly in LOAD)
//   fir_c_we   : coefficient write enable, one cycle after a handshake
//   fir_c_in   : coefficient write data
//   fir_c_addr : coefficient write address
//   mute       : filter output invalid (LOAD and SETTLE)
//   busy       : loader not in IDLE
//   done       : one-cycle pulse on successful completion
//   err        : sticky timeout/abort flag, cleared by the next start
module fir_coeff_loader
    import fir_pkg::*;
#(
    parameter  int ORD        = 256,
    parameter  int COEFF_SIZE = 16,
    parameter  int D          = 52,
    parameter  int TIMEOUT    = 1024,
    localparam int NCOEF      = ncoef(ORD),
    localparam int AW         = addr_width(ORD)
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  s_valid,
    input  logic [COEFF_SIZE-1:0] s_data,
    output logic                  s_ready,
    output logic                  fir_c_we,
    output logic [COEFF_SIZE-1:0] fir_c_in,
    output logic [AW-1:0]         fir_c_addr,
    output logic                  mute,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    // The timer must hold both TIMEOUT-1 and 2*D-1.
    localparam int TMAX = (TIMEOUT > 2 * D) ? TIMEOUT : 2 * D;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    // The reload values are one less than the count. The zero cycle is
    // itself the final counted cycle.
    localparam logic [TW-1:0] TIMEOUT_RELOAD = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] SETTLE_RELOAD  = TW'(2 * D - 1);
    localparam logic [AW-1:0] LAST_INDEX     = AW'(NCOEF - 1);

    loader_state_t state;
    loader_state_t next_state;

    logic [AW-1:0] index;
    logic          handshake;
    logic          last_beat;
    logic          begin_load;
    logic          timed_out;

    logic          timer_load;
    logic          timer_dec;
    logic [TW-1:0] timer_value;
    logic          timer_zero;

    logic          s_ready_d;
    logic          mute_d;
    logic          busy_d;
    logic          done_d;
    logic          err_d;

    // s_ready is registered from next_state, so it is high exactly in LOAD.
    assign handshake  = s_valid && s_ready;
    assign last_beat  = (index == LAST_INDEX);
    assign begin_load = (state == IDLE) && start && !abort;
    assign timed_out  = (state == LOAD) && !handshake && timer_zero;

    loader_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk        (clk),
        .nrst       (nrst),
        .load       (timer_load),
        .load_value (timer_value),
        .dec        (timer_dec),
        .zero       (timer_zero)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (begin_load) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (handshake && last_beat) begin
                    next_state = SETTLE;
                end else if (timed_out) begin
                    next_state = IDLE;
                end
            end
            SETTLE: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (timer_zero) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // The timer is reloaded with the timeout on start and on every beat.
    // The last beat reloads it with the settle length instead.
    always_comb begin
        timer_load  = 1'b0;
        timer_dec   = 1'b0;
        timer_value = TIMEOUT_RELOAD;
        case (state)
            IDLE: begin
                timer_load = begin_load;
            end
            LOAD: begin
                if (handshake) begin
                    timer_load = 1'b1;
                    if (last_beat) begin
                        timer_value = SETTLE_RELOAD;
                    end
                end else begin
                    timer_dec = !timer_zero;
                end
            end
            SETTLE: begin
                timer_dec = !timer_zero;
            end
            default: begin
                timer_load = 1'b0;
            end
        endcase
    end

    // The index stops at the last address instead of wrapping.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            index <= '0;
        end else if (begin_load) begin
            index <= '0;
        end else if (handshake && !last_beat) begin
            index <= index + AW'(1);
        end
    end

    // Status outputs follow next_state, so they line up with the state register.
    always_comb begin
        s_ready_d = (next_state == LOAD);
        mute_d    = (next_state == LOAD) || (next_state == SETTLE);
        busy_d    = (next_state != IDLE);
        done_d    = (next_state == DONE);
        err_d     = err;
        if (begin_load) begin
            err_d = 1'b0;
        end else if ((state != IDLE) && abort) begin
            err_d = 1'b1;
        end else if (timed_out) begin
            err_d = 1'b1;
        end
    end

    // Data and address are updated only on a write; the filter ignores them otherwise.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s_ready    <= 1'b0;
            mute       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            fir_c_we   <= 1'b0;
            fir_c_in   <= '0;
            fir_c_addr <= '0;
        end else begin
            s_ready  <= s_ready_d;
            mute     <= mute_d;
            busy     <= busy_d;
            done     <= done_d;
            err      <= err_d;
            fir_c_we <= handshake;
            if (handshake) begin
                fir_c_in   <= s_data;
                fir_c_addr <= index;
            end
        end
    end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// tb_fir_coeff_loader
// Directed and randomized stimulus for fir_coeff_loader. Every output is
// compared against a behavioural model each cycle, using counters and
// integer modes. Scenario-level counts are checked at the end of each
// scenario.
module tb_fir_coeff_loader;

    localparam int ORD           = 256;
    localparam int COEFF_SIZE    = 16;
    localparam int D             = 52;
    localparam int TIMEOUT       = 1024;
    localparam int NCOEF         = (ORD + 1) / 2;
    localparam int AW            = $clog2(NCOEF);
    localparam int SETTLE_CYCLES = 2 * D;

    localparam int M_IDLE   = 0;
    localparam int M_LOAD   = 1;
    localparam int M_SETTLE = 2;
    localparam int M_DONE   = 3;

    logic                  clk;
    logic                  nrst;
    logic                  start;
    logic                  abort;
    logic                  s_valid;
    logic [COEFF_SIZE-1:0] s_data;
    logic                  s_ready;
    logic                  fir_c_we;
    logic [COEFF_SIZE-1:0] fir_c_in;
    logic [AW-1:0]         fir_c_addr;
    logic                  mute;
    logic                  busy;
    logic                  done;
    logic                  err;

    int errors = 0;
    int checks = 0;

    int                    m_mode;
    int                    m_idx;
    int                    m_idle;
    int                    m_settle;
    logic                  m_err;
    logic                  m_we;
    logic [AW-1:0]         m_addr;
    logic [COEFF_SIZE-1:0] m_data;

    int writes_seen;
    int dones_seen;
    int settle_seen;

    fir_coeff_loader #(
        .ORD        (ORD),
        .COEFF_SIZE (COEFF_SIZE),
        .D          (D),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .start      (start),
        .abort      (abort),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .fir_c_we   (fir_c_we),
        .fir_c_in   (fir_c_in),
        .fir_c_addr (fir_c_addr),
        .mute       (mute),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode   = M_IDLE;
        m_idx    = 0;
        m_idle   = 0;
        m_settle = 0;
        m_err    = 1'b0;
        m_we     = 1'b0;
        m_addr   = '0;
        m_data   = '0;
    endtask

    // One clock edge of the loader's specified behaviour
    task automatic model_step(input logic st, input logic ab, input logic v,
                              input logic [COEFF_SIZE-1:0] d);
        logic hs;
        hs   = (m_mode == M_LOAD) && v;
        m_we = hs;
        if (hs) begin
            m_addr = AW'(m_idx);
            m_data = d;
        end
        case (m_mode)
            M_IDLE: begin
                if (st && !ab) begin
                    m_mode = M_LOAD;
                    m_idx  = 0;
                    m_idle = 0;
                    m_err  = 1'b0;
                end
            end
            M_LOAD: begin
                if (ab) begin
                    m_mode = M_IDLE;
                    m_err  = 1'b1;
                end else if (hs) begin
                    m_idle = 0;
                    if (m_idx == NCOEF - 1) begin
                        m_mode   = M_SETTLE;
                        m_settle = 0;
                    end else begin
                        m_idx++;
                    end
                end else begin
                    m_idle++;
                    if (m_idle == TIMEOUT) begin
                        m_mode = M_IDLE;
                        m_err  = 1'b1;
                    end
                end
            end
            M_SETTLE: begin
                if (ab) begin
                    m_mode = M_IDLE;
                    m_err  = 1'b1;
                end else begin
                    m_settle++;
                    if (m_settle == SETTLE_CYCLES) m_mode = M_DONE;
                end
            end
            default: begin
                if (ab) m_err = 1'b1;
                m_mode = M_IDLE;
            end
        endcase
    endtask

    task automatic check_output();
        check_bit("s_ready", s_ready, m_mode == M_LOAD);
        check_bit("mute", mute, (m_mode == M_LOAD) || (m_mode == M_SETTLE));
        check_bit("busy", busy, m_mode != M_IDLE);
        check_bit("done", done, m_mode == M_DONE);
        check_bit("err", err, m_err);
        check_bit("fir_c_we", fir_c_we, m_we);
        if (m_we) begin
            check_vec("fir_c_addr", 32'(fir_c_addr), 32'(m_addr));
            check_vec("fir_c_in", 32'(fir_c_in), 32'(m_data));
        end
        if (fir_c_we === 1'b1) begin
            check_vec("addr_sequence", 32'(fir_c_addr), 32'(writes_seen));
            writes_seen++;
        end
        if (done === 1'b1) dones_seen++;
        if (mute === 1'b1 && s_ready === 1'b0) settle_seen++;
    endtask

    task automatic check_reset_values(input string tag);
        check_bit({tag, "_s_ready"}, s_ready, 1'b0);
        check_bit({tag, "_fir_c_we"}, fir_c_we, 1'b0);
        check_bit({tag, "_mute"}, mute, 1'b0);
        check_bit({tag, "_busy"}, busy, 1'b0);
        check_bit({tag, "_done"}, done, 1'b0);
        check_bit({tag, "_err"}, err, 1'b0);
        check_vec({tag, "_fir_c_in"}, 32'(fir_c_in), 32'd0);
        check_vec({tag, "_fir_c_addr"}, 32'(fir_c_addr), 32'd0);
    endtask

    task automatic apply_stimulus(input logic st, input logic ab, input logic v,
                                  input logic [COEFF_SIZE-1:0] d);
        @(negedge clk);
        start   = st;
        abort   = ab;
        s_valid = v;
        s_data  = d;
        @(posedge clk);
        if (nrst) model_step(st, ab, v, d);
        else model_reset();
        #1;
        check_output();
    endtask

    task automatic clear_counters();
        writes_seen = 0;
        dones_seen  = 0;
        settle_seen = 0;
    endtask

    task automatic run_settle(input int n);
        for (int i = 0; i < n; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'($urandom % 2), COEFF_SIZE'($urandom));
        end
    endtask

    task automatic full_load(input string tag);
        clear_counters();
        apply_stimulus(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < NCOEF; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b1, COEFF_SIZE'($urandom));
        end
        run_settle(SETTLE_CYCLES + 6);
        check_vec({tag, "_writes"}, 32'(writes_seen), 32'(NCOEF));
        check_vec({tag, "_dones"}, 32'(dones_seen), 32'd1);
        check_vec({tag, "_settle_len"}, 32'(settle_seen), 32'(SETTLE_CYCLES));
    endtask

    initial begin
        int err_at;
        int gap_cycles;

        nrst    = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        model_reset();
        clear_counters();
        #1;
        check_reset_values("por");
        repeat (3) apply_stimulus(1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        nrst = 1'b1;

        // start and abort together in IDLE with err low
        apply_stimulus(1'b1, 1'b1, 1'b0, '0);
        check_bit("start_abort_busy", busy, 1'b0);
        check_bit("start_abort_ready", s_ready, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 16'h1234);

        // back-to-back beats, data = index+1
        $display("[TB] back-to-back load");
        clear_counters();
        apply_stimulus(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < NCOEF; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b1, COEFF_SIZE'(i + 1));
        end
        run_settle(SETTLE_CYCLES + 6);
        check_vec("b2b_writes", 32'(writes_seen), 32'(NCOEF));
        check_vec("b2b_dones", 32'(dones_seen), 32'd1);
        check_vec("b2b_settle_len", 32'(settle_seen), 32'(SETTLE_CYCLES));

        // s_valid toggling, with start ignored outside IDLE
        $display("[TB] toggling valid load");
        clear_counters();
        apply_stimulus(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 2 * NCOEF - 1; i++) begin
            apply_stimulus(1'($urandom % 2), 1'b0, (i % 2) == 0, COEFF_SIZE'($urandom));
        end
        run_settle(SETTLE_CYCLES + 6);
        check_vec("toggle_writes", 32'(writes_seen), 32'(NCOEF));
        check_vec("toggle_dones", 32'(dones_seen), 32'd1);

        // timeout after 10 beats
        $display("[TB] timeout load");
        clear_counters();
        err_at = -1;
        apply_stimulus(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b1, COEFF_SIZE'($urandom));
        end
        for (int n = 1; n <= TIMEOUT + 40; n++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, COEFF_SIZE'($urandom));
            if (err === 1'b1 && err_at < 0) err_at = n;
        end
        check_vec("timeout_delay", 32'(err_at), 32'(TIMEOUT));
        check_vec("timeout_writes", 32'(writes_seen), 32'd10);
        check_bit("timeout_busy", busy, 1'b0);
        check_bit("timeout_err", err, 1'b1);
        repeat (4) apply_stimulus(1'b0, 1'b0, 1'b1, COEFF_SIZE'($urandom));
        check_vec("timeout_no_late_writes", 32'(writes_seen), 32'd10);

        // start and abort together in IDLE with err high
        apply_stimulus(1'b1, 1'b1, 1'b0, '0);
        check_bit("start_abort_err_kept", err, 1'b1);
        check_bit("start_abort_idle", busy, 1'b0);
        check_bit("start_abort_ready2", s_ready, 1'b0);

        // abort in cycle 20 of SETTLE
        $display("[TB] abort during settle");
        clear_counters();
        apply_stimulus(1'b1, 1'b0, 1'b0, '0);
        check_bit("restart_clears_err", err, 1'b0);
        gap_cycles = 0;
        while (m_mode == M_LOAD && gap_cycles < 1000) begin
            apply_stimulus(1'b0, 1'b0, ($urandom % 3) != 0, COEFF_SIZE'($urandom));
            gap_cycles++;
        end
        check_bit("gap_reached_settle", mute && !s_ready, 1'b1);
        check_vec("gap_writes", 32'(writes_seen), 32'(NCOEF));
        for (int k = 1; k < 20; k++) apply_stimulus(1'b0, 1'b0, 1'b0, '0);
        apply_stimulus(1'b0, 1'b1, 1'b0, '0);
        check_bit("abort_idle", busy, 1'b0);
        check_bit("abort_err", err, 1'b1);
        check_bit("abort_unmute", mute, 1'b0);
        run_settle(SETTLE_CYCLES + 20);
        check_vec("abort_no_done", 32'(dones_seen), 32'd0);
        full_load("after_abort");
        check_bit("after_abort_err", err, 1'b0);

        // reset at beat 64
        $display("[TB] reset mid-load");
        clear_counters();
        apply_stimulus(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 64; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b1, COEFF_SIZE'($urandom));
        end
        @(negedge clk);
        #2;
        nrst = 1'b0;
        #1;
        model_reset();
        check_reset_values("async_rst");
        repeat (2) apply_stimulus(1'b0, 1'b0, 1'b1, COEFF_SIZE'($urandom));
        @(negedge clk);
        nrst = 1'b1;
        repeat (3) apply_stimulus(1'b0, 1'b0, 1'b1, COEFF_SIZE'($urandom));
        check_bit("post_rst_idle", busy, 1'b0);
        full_load("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
